// File: rtl/life_scheduler.sv
// life_scheduler: paces the Game-of-Life engine against VGA frame timing.
// Launches a generation (free-run at speed+1 frames per generation, or one
// step while paused) or a pattern reload, waits for the engine, and swaps
// the displayed buffer only on the vsync falling edge so the picture never
// tears. A watchdog flags an engine that never answers.
module life_scheduler #(
    parameter int SPD_W   = 4,
    parameter int GEN_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             run,
    input  logic             step,
    input  logic             load,
    input  logic [SPD_W-1:0] speed,
    input  logic             eng_done,
    output logic             eng_start,
    output logic             eng_load,
    output logic             buf_swap,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             err
);

    // The watchdog counts cycles spent in WAIT. The error registers on the
    // edge where that count reaches TIMEOUT, so err rises exactly TIMEOUT
    // cycles after the eng_start/eng_load pulse.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic {
        KIND_GEN  = 1'b0,
        KIND_LOAD = 1'b1
    } kind_t;

    state_t            state;
    kind_t             kind;
    logic [WD_W-1:0]   watchdog;
    logic [SPD_W-1:0]  frame_cnt;
    logic              vsync_q;
    logic              step_q;
    logic              load_q;
    logic              load_pend;
    logic              step_pend;

    logic              tick;
    logic              load_edge;
    logic              step_edge;
    logic              run_due;
    logic              due;
    logic              launch_ok;
    logic              load_launch;
    logic              gen_launch;

    // Frame counter saturates rather than wrapping, so a long pause in the
    // count can never make a pending run launch disappear.
    function automatic logic [SPD_W-1:0] sat_inc(input logic [SPD_W-1:0] v);
        logic [SPD_W-1:0] r;
        r = (&v) ? v : v + 1'b1;
        return r;
    endfunction

    // Frame tick, button edges and the launch decision.
    assign tick        = vsync_q & ~vsync;
    assign load_edge   = load & ~load_q;
    assign step_edge   = step & ~step_q & ~run;
    assign run_due     = run & (frame_cnt >= speed);
    assign due         = load_pend | run_due | (~run & step_pend);
    assign launch_ok   = tick & due & ((state == IDLE) | (state == HOLD));
    assign load_launch = launch_ok & load_pend;
    assign gen_launch  = launch_ok & ~load_pend;

    // Edge-detect history; zero at reset so a button held through reset
    // release is seen as one press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            step_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            step_q  <= step;
            load_q  <= load;
        end
    end

    // Pending requests: a fresh edge wins over the clear of a launch that
    // happens in the same cycle, so no press is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_pend <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            load_pend <= (load_pend & ~load_launch) | load_edge;
            step_pend <= (step_pend & ~gen_launch) | step_edge;
        end
    end

    // Frames since the last compute launch; counts in every state, held
    // at zero while paused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (!run) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= gen_launch ? '0 : sat_inc(frame_cnt);
        end
    end

    // Sequencer: launch, wait for the engine, swap at the next frame edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            kind      <= KIND_GEN;
            watchdog  <= '0;
            eng_start <= 1'b0;
            eng_load  <= 1'b0;
            buf_swap  <= 1'b0;
            gen_count <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            eng_load  <= 1'b0;
            buf_swap  <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_ok) begin
                        eng_load  <= load_pend;
                        eng_start <= ~load_pend;
                        kind      <= load_pend ? KIND_LOAD : KIND_GEN;
                        watchdog  <= '0;
                        state     <= WAIT;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (eng_done) begin
                        state <= HOLD;
                    end else if (watchdog == WD_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        buf_swap  <= 1'b1;
                        gen_count <= (kind == KIND_LOAD) ? '0 : gen_count + 1'b1;
                        if (launch_ok) begin
                            eng_load  <= load_pend;
                            eng_start <= ~load_pend;
                            kind      <= load_pend ? KIND_LOAD : KIND_GEN;
                            watchdog  <= '0;
                            state     <= WAIT;
                            busy      <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_scheduler.sv
// Directed bench for life_scheduler: frame-by-frame expectations are queued
// when each vsync fall is driven and compared when the command cycle arrives.
module tb_life_scheduler;

    localparam int SPD_W = 4;
    localparam int GEN_W = 16;
    localparam int TO    = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic             vsync;
    logic             run;
    logic             step;
    logic             load;
    logic [SPD_W-1:0] speed;
    logic             eng_done;
    logic             eng_done_auto = 1'b0;
    logic             eng_done_man  = 1'b0;
    logic             eng_en        = 1'b1;
    logic             eng_start;
    logic             eng_load;
    logic             buf_swap;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             err;

    assign eng_done = eng_done_auto | eng_done_man;

    life_scheduler #(
        .SPD_W  (SPD_W),
        .GEN_W  (GEN_W),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .vsync    (vsync),
        .run      (run),
        .step     (step),
        .load     (load),
        .speed    (speed),
        .eng_done (eng_done),
        .eng_start(eng_start),
        .eng_load (eng_load),
        .buf_swap (buf_swap),
        .gen_count(gen_count),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             s;
        logic             l;
        logic             w;
        logic [GEN_W-1:0] g;
        logic             e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fno    = 0;
    int   n_start = 0;
    int   n_load  = 0;
    int   n_swap  = 0;
    int   done_cnt = 0;

    // Engine model: answers 10 cycles after each command when enabled.
    always @(negedge clk) begin
        eng_done_auto = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) eng_done_auto = 1'b1;
        end
        if (eng_en && (eng_start === 1'b1 || eng_load === 1'b1)) done_cnt = 10;
    end

    // Pulse tallies, to catch commands or swaps outside the expected frames.
    always @(negedge clk) begin
        if (eng_start === 1'b1) n_start++;
        if (eng_load === 1'b1)  n_load++;
        if (buf_swap === 1'b1)  n_swap++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t mk(input logic s, input logic l, input logic w,
                                input logic [GEN_W-1:0] g, input logic e);
        exp_t x;
        x.s = s; x.l = l; x.w = w; x.g = g; x.e = e;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t x, input string pfx);
        chk({pfx, ".eng_start"}, 32'(eng_start), 32'(x.s));
        chk({pfx, ".eng_load"},  32'(eng_load),  32'(x.l));
        chk({pfx, ".buf_swap"},  32'(buf_swap),  32'(x.w));
        chk({pfx, ".gen_count"}, 32'(gen_count), 32'(x.g));
        chk({pfx, ".err"},       32'(err),       32'(x.e));
    endtask

    // One video frame: vsync falls, the command cycle is checked, then the
    // frame runs out long enough for the engine model to answer.
    task automatic frame(input logic s, input logic l, input logic w,
                         input logic [GEN_W-1:0] g, input logic e);
        exp_t x;
        fno++;
        @(negedge clk);
        sb.push_back(mk(s, l, w, g, e));
        vsync = 1'b0;
        @(negedge clk);
        x = sb.pop_front();
        check_outputs(x, $sformatf("f%0d", fno));
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic press(input logic do_step, input logic do_load);
        @(negedge clk);
        step = do_step;
        load = do_load;
        repeat (2) @(negedge clk);
        step = 1'b0;
        load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_t x;
        int   found;
        logic busy_at;
        int   s0;
        int   w0;

        reset = 1'b1;
        vsync = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        load  = 1'b0;
        speed = '0;

        // Reset state
        @(negedge clk);
        check_outputs(mk(0, 0, 0, 0, 0), "reset");
        chk("reset.busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Free-run at one generation per frame
        run = 1'b1;
        speed = 4'd0;
        s0 = n_start;
        frame(1, 0, 0, 16'd0, 0);
        frame(1, 0, 1, 16'd1, 0);
        frame(1, 0, 1, 16'd2, 0);
        frame(1, 0, 1, 16'd3, 0);
        run = 1'b0;
        frame(0, 0, 1, 16'd4, 0);
        chk("run0.start_total", 32'(n_start - s0), 32'd4);

        // Paused single step, then a step press while running is ignored
        press(1'b1, 1'b0);
        s0 = n_start;
        w0 = n_swap;
        frame(1, 0, 0, 16'd4, 0);
        frame(0, 0, 1, 16'd5, 0);
        frame(0, 0, 0, 16'd5, 0);
        chk("step.start_total", 32'(n_start - s0), 32'd1);
        chk("step.swap_total",  32'(n_swap - w0),  32'd1);
        run = 1'b1;
        speed = 4'd15;
        press(1'b1, 1'b0);
        frame(0, 0, 0, 16'd5, 0);
        run = 1'b0;
        frame(0, 0, 0, 16'd5, 0);

        // speed=3: launch every 4th frame; lowering speed acts at next tick
        run = 1'b1;
        speed = 4'd3;
        frame(0, 0, 0, 16'd5, 0);
        frame(0, 0, 0, 16'd5, 0);
        frame(0, 0, 0, 16'd5, 0);
        s0 = n_start;
        frame(1, 0, 0, 16'd5, 0);
        frame(0, 0, 1, 16'd6, 0);
        frame(0, 0, 0, 16'd6, 0);
        frame(0, 0, 0, 16'd6, 0);
        frame(1, 0, 0, 16'd6, 0);
        frame(0, 0, 1, 16'd7, 0);
        frame(0, 0, 0, 16'd7, 0);
        frame(0, 0, 0, 16'd7, 0);
        frame(1, 0, 0, 16'd7, 0);
        chk("spd3.start_total", 32'(n_start - s0), 32'd3);
        frame(0, 0, 1, 16'd8, 0);
        frame(0, 0, 0, 16'd8, 0);
        speed = 4'd0;
        frame(1, 0, 0, 16'd8, 0);
        run = 1'b0;
        frame(0, 0, 1, 16'd9, 0);

        // Load and step in the same cycle: load first, then the step
        press(1'b1, 1'b1);
        frame(0, 1, 0, 16'd9, 0);
        frame(1, 0, 1, 16'd0, 0);
        frame(0, 0, 1, 16'd1, 0);
        frame(0, 0, 0, 16'd1, 0);

        // Engine never answers: watchdog error after TO cycles
        eng_en = 1'b0;
        press(1'b1, 1'b0);
        w0 = n_swap;
        @(negedge clk);
        sb.push_back(mk(1, 0, 0, 16'd1, 0));
        vsync = 1'b0;
        @(negedge clk);
        x = sb.pop_front();
        check_outputs(x, "to.launch");
        found = -1;
        busy_at = 1'b1;
        for (int n = 1; n <= TO + 20; n++) begin
            @(negedge clk);
            if (n == 3) vsync = 1'b1;
            if (found < 0 && err === 1'b1) begin
                found = n;
                busy_at = busy;
            end
        end
        chk("to.err_cycle", 32'(found), 32'(TO));
        chk("to.busy", 32'(busy_at), 32'd0);
        chk("to.swap_total", 32'(n_swap - w0), 32'd0);
        chk("to.gen_count", 32'(gen_count), 32'd1);
        press(1'b1, 1'b0);
        frame(1, 0, 0, 16'd1, 1);

        // Asynchronous reset mid-WAIT, then a stray done is ignored
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_outputs(mk(0, 0, 0, 0, 0), "rst_async");
        chk("rst_async.busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        eng_done_man = 1'b1;
        @(negedge clk);
        eng_done_man = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_after.busy", 32'(busy), 32'd0);
        w0 = n_swap;
        frame(0, 0, 0, 16'd0, 0);
        chk("rst_after.swap_total", 32'(n_swap - w0), 32'd0);

        // Load button held through reset release counts as one press
        @(negedge clk);
        reset = 1'b1;
        load = 1'b1;
        eng_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        frame(0, 1, 0, 16'd0, 0);
        load = 1'b0;
        frame(0, 0, 1, 16'd0, 0);
        frame(0, 0, 0, 16'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
